mbist_controller: RTL and testbench
===================================

// Module: mbist_controller
// PURPOSE
//  Initiator side of the memory wrapper's MBIST port. Runs a March C- test on the
//  attached RAM when started. Drives test_mode, mbist_rd, mbist_wr, mbist_addr and
//  mbist_din, and compares the read data returned on mem_dout.
//  Reports done, pass/fail and the first failing address and data word.
// PARAMETERS
//  addr  4  address width; depth N = 2**addr words
//  data  8  data width; background 0 = all zeros, background 1 = all ones
// PORTS
//  clk         in   1     single clock; all state updates on its rising edge
//  rst         in   1     synchronous, active-high reset
//  start       in   1     1-cycle pulse; sampled in IDLE/DONE only
//  mem_dout    in   data  RAM read data; valid the cycle after mbist_rd=1
//  test_mode   out  1     wrapper select; 1 = MBIST owns the RAM
//  mbist_rd    out  1     read strobe
//  mbist_wr    out  1     write strobe (never 1 together with mbist_rd)
//  mbist_addr  out  addr  RAM address
//  mbist_din   out  data  write data
//  done        out  1     test finished; held until next start or rst
//  fail        out  1     sticky mismatch flag, valid while done=1
//  fail_addr   out  addr  address of first mismatch
//  fail_data   out  data  mem_dout value captured at first mismatch
// BEHAVIOUR
//  - Outputs: all outputs are registered. rst forces every output to 0 and state
//    to IDLE on the next edge, including mid-test.
//  - States:
//    IDLE -start-> RUN
//    RUN  -last op of element 5-> DRAIN
//    RUN  -mismatch-> DONE
//    DRAIN -> DONE
//    DONE -start-> RUN
//  - test_mode: 1 in RUN and DRAIN; 0 in IDLE and DONE.
//  - March elements, in order:
//    e0 up(w0); e1 up(r0,w1); e2 up(r1,w0); e3 down(r0,w1); e4 down(r1,w0); e5 up(r0)
//  - Address order: up = 0..N-1; down = N-1..0. No wrap-around within an element.
//    The address counter reloads at each element boundary.
//  - Operation rate: one operation per cycle. A r,w pair hits the same address on
//    consecutive cycles, then the address steps.
//  - Compare timing: the compare for a read issued in cycle t happens in cycle t+1
//    against the expected background. This overlaps the write or next read in that
//    cycle. DRAIN exists only to compare the final e5 read.
//  - Cycle budget: RUN lasts 10*N cycles, followed by 1 DRAIN cycle.
//  - Start-to-done timing: start is sampled at edge k. The first mbist_wr=1
//    (addr 0, din 0) appears after edge k+1. done=1 appears after edge k+10N+2.
//    For addr=4 this is 162 cycles after the start edge.
//  - Mismatch: on the first mismatch, fail=1, fail_addr=address of that read and
//    fail_data=mem_dout are latched. Go to DONE on the next edge and stop issuing
//    ops. rd, wr and test_mode drop to 0.
//  - start: ignored in RUN and DRAIN. start in DONE clears done, fail, fail_addr and
//    fail_data, then restarts from e0.
//  - Idle outputs: in IDLE and DONE, mbist_rd, mbist_wr, mbist_addr and mbist_din
//    are all 0.
// TESTING
//  1. Fault-free RAM model, addr=4/data=8. start pulse -> test_mode=1 next cycle,
//     160 ops, done=1 at start edge +162, fail=0.
//  2. Op trace check. First 16 cycles: wr, din=0x00, addr 0..15. Element e3 runs
//     addr 15..0 with din=0xFF on its writes. rd and wr are never both 1.
//  3. Bit 3 stuck-at-0 at addr 5 -> fail found in e2 read; fail=1, fail_addr=5,
//     fail_data=0xF7. State goes to DONE the cycle after the compare.
//  4. Bit 0 stuck-at-1 at addr 0 -> e1 first read; fail_addr=0, fail_data=0x01.
//     done is asserted 19 edges after start.
//  5. rst asserted 50 cycles into RUN -> all outputs 0 next edge. A new start then
//     completes a clean run with fail=0.
//  6. start pulsed mid-RUN -> no effect on the op sequence. start in DONE after
//     test 3 -> fail cleared and a full run restarts at addr 0.

Source files
------------

// File: rtl/mbist_controller_if.sv
// MBIST port between the controller (master) and the memory wrapper (slave).
// Purely combinational bundle; no flow control beyond the rd/wr strobes.
interface mbist_controller_if #(
    parameter int addr = 4,
    parameter int data = 8
);
    logic            test_mode;
    logic            mbist_rd;
    logic            mbist_wr;
    logic [addr-1:0] mbist_addr;
    logic [data-1:0] mbist_din;
    logic [data-1:0] mem_dout;

    modport master (
        output test_mode, mbist_rd, mbist_wr, mbist_addr, mbist_din,
        input  mem_dout
    );

    modport slave (
        input  test_mode, mbist_rd, mbist_wr, mbist_addr, mbist_din,
        output mem_dout
    );
endinterface

// File: rtl/mbist_controller.sv
// March C- initiator: one RAM op per cycle, done 10*N+2 edges after start, first mismatch latched.
// No backpressure: the RAM must accept an op every cycle and return read data one cycle later.
module mbist_controller #(
    parameter int addr = 4,
    parameter int data = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    mbist_controller_if.master mem,
    output logic               done,
    output logic               fail,
    output logic [addr-1:0]    fail_addr,
    output logic [data-1:0]    fail_data
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [2:0]      elem;
    logic [addr-1:0] cnt;
    logic            phase;
    logic            issued_all;
    logic [data-1:0] rd_exp;
    logic            cmp_vld;
    logic [addr-1:0] cmp_addr;
    logic [data-1:0] cmp_exp;

    logic            pair, down, bg, step, mismatch;
    logic            op_rd, op_wr;
    logic [data-1:0] bgv, op_dat;
    logic [addr-1:0] op_addr;

    // Elements 1..4 are (read, write) pairs; 0 and 5 are single ops.
    always_comb begin
        pair     = (elem >= 3'd1) && (elem <= 3'd4);
        down     = (elem == 3'd3) || (elem == 3'd4);
        bg       = (elem == 3'd2) || (elem == 3'd4);
        bgv      = {data{bg}};
        op_rd    = (elem == 3'd5) || (pair && !phase);
        op_wr    = (elem == 3'd0) || (pair && phase);
        op_dat   = (pair && phase) ? ~bgv : bgv;
        op_addr  = down ? ~cnt : cnt;
        step     = !pair || phase;
        mismatch = cmp_vld && (mem.mem_dout != cmp_exp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            elem           <= '0;
            cnt            <= '0;
            phase          <= 1'b0;
            issued_all     <= 1'b0;
            rd_exp         <= '0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            cmp_exp        <= '0;
            mem.test_mode  <= 1'b0;
            mem.mbist_rd   <= 1'b0;
            mem.mbist_wr   <= 1'b0;
            mem.mbist_addr <= '0;
            mem.mbist_din  <= '0;
            done           <= 1'b0;
            fail           <= 1'b0;
            fail_addr      <= '0;
            fail_data      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        mem.test_mode <= 1'b1;
                        done          <= 1'b0;
                        fail          <= 1'b0;
                        fail_addr     <= '0;
                        fail_data     <= '0;
                        elem          <= '0;
                        cnt           <= '0;
                        phase         <= 1'b0;
                        issued_all    <= 1'b0;
                        cmp_vld       <= 1'b0;
                    end
                end
                default: begin
                    // Read data arrives one cycle after the strobe, so the compare
                    // context trails the issued op by one register stage.
                    cmp_vld  <= mem.mbist_rd;
                    cmp_addr <= mem.mbist_addr;
                    cmp_exp  <= rd_exp;
                    if (mismatch) begin
                        state          <= DONE;
                        done           <= 1'b1;
                        fail           <= 1'b1;
                        fail_addr      <= cmp_addr;
                        fail_data      <= mem.mem_dout;
                        cmp_vld        <= 1'b0;
                        mem.test_mode  <= 1'b0;
                        mem.mbist_rd   <= 1'b0;
                        mem.mbist_wr   <= 1'b0;
                        mem.mbist_addr <= '0;
                        mem.mbist_din  <= '0;
                    end else if (state == DRAIN) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        mem.test_mode <= 1'b0;
                    end else if (issued_all) begin
                        state          <= DRAIN;
                        mem.mbist_rd   <= 1'b0;
                        mem.mbist_wr   <= 1'b0;
                        mem.mbist_addr <= '0;
                        mem.mbist_din  <= '0;
                    end else begin
                        mem.mbist_rd   <= op_rd;
                        mem.mbist_wr   <= op_wr;
                        mem.mbist_addr <= op_addr;
                        mem.mbist_din  <= op_wr ? op_dat : '0;
                        rd_exp         <= op_dat;
                        phase          <= pair && !phase;
                        if (step) begin
                            if (cnt == '1) begin
                                cnt  <= '0;
                                elem <= 3'(elem + 3'd1);
                                if (elem == 3'd5) issued_all <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mbist_controller.sv
// Drives the March C- controller against a stuck-at RAM model and checks trace, timing and results.
module tb_mbist_controller;
    localparam int N = 16;

    logic       clk, rst, start;
    logic       done, fail;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;

    mbist_controller_if #(.addr(4), .data(8)) mif ();

    mbist_controller #(.addr(4), .data(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem       (mif),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Fault injected on reads of one cell: selected bits forced to 0 or 1.
    bit         f_en;
    logic [3:0] f_addr;
    logic [7:0] f_mask;
    bit         f_sa1;

    logic [7:0] ram [N];

    function automatic logic [7:0] faulty(input logic [7:0] v, input logic [3:0] a);
        if (f_en && a == f_addr) return f_sa1 ? (v | f_mask) : (v & ~f_mask);
        return v;
    endfunction

    always @(posedge clk) begin
        if (mif.test_mode && mif.mbist_wr) ram[mif.mbist_addr] <= mif.mbist_din;
        if (mif.test_mode && mif.mbist_rd) mif.mem_dout <= faulty(ram[mif.mbist_addr], mif.mbist_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [3:0] a;
        logic [7:0] d;
    } op_t;

    op_t exp_ops[$];
    op_t obs_ops[$];

    // March C- as a table: op codes 0=r0 1=r1 2=w0 3=w1.
    int march_nops [6]    = '{1, 2, 2, 2, 2, 1};
    bit march_down [6]    = '{0, 0, 0, 1, 1, 0};
    int march_op   [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};

    task automatic build_ops();
        exp_ops.delete();
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < march_nops[e]; k++) begin
                    op_t o;
                    int  code = march_op[e][k];
                    o.rd = (code < 2);
                    o.wr = (code >= 2);
                    o.a  = 4'(march_down[e] ? N - 1 - i : i);
                    o.d  = (code % 2 == 1) ? 8'hFF : 8'h00;
                    exp_ops.push_back(o);
                end
    endtask

    int         e_nops, e_done;
    bit         e_fail;
    logic [3:0] e_faddr;
    logic [7:0] e_fdata;

    // Replay the march on an ideal array with the fault; a read issued as op j
    // is judged at edge j+3 after start, by which time ops 0..j+1 have gone out.
    task automatic ref_run();
        logic [7:0] mm [N];
        e_fail  = 0;
        e_faddr = '0;
        e_fdata = '0;
        e_nops  = 10 * N;
        e_done  = 10 * N + 2;
        for (int j = 0; j < exp_ops.size(); j++) begin
            op_t o = exp_ops[j];
            if (o.wr) mm[o.a] = o.d;
            else if (faulty(mm[o.a], o.a) != o.d) begin
                e_fail  = 1;
                e_faddr = o.a;
                e_fdata = faulty(mm[o.a], o.a);
                e_done  = j + 3;
                e_nops  = (j + 2 < 10 * N) ? j + 2 : 10 * N;
                break;
            end
        end
    endtask

    int done_cyc;

    task automatic run_test(input int mid_start, input int rst_at);
        bit got_done = 0;
        int both     = 0;
        ref_run();
        obs_ops.delete();
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("test_mode_after_start", mif.test_mode, 1);
        chk("done_cleared", done, 0);
        chk("fail_cleared", {fail, fail_addr, fail_data}, 0);
        for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
            if (cyc == mid_start) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (mif.mbist_rd && mif.mbist_wr) both++;
            if (mif.mbist_rd || mif.mbist_wr) begin
                op_t o;
                o.rd = mif.mbist_rd;
                o.wr = mif.mbist_wr;
                o.a  = mif.mbist_addr;
                o.d  = mif.mbist_wr ? mif.mbist_din : 8'h00;
                obs_ops.push_back(o);
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            if (rst_at != 0 && cyc == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("rst_outputs_zero",
                    {mif.test_mode, mif.mbist_rd, mif.mbist_wr, mif.mbist_addr,
                     mif.mbist_din, done, fail, fail_addr, fail_data}, 0);
                return;
            end
        end
        chk("done_seen", got_done, 1);
        chk("done_cycle", done_cyc, e_done);
        chk("op_count", obs_ops.size(), e_nops);
        for (int i = 0; i < obs_ops.size() && i < e_nops; i++) begin
            op_t x = exp_ops[i];
            if (!x.wr) x.d = 8'h00;
            chk($sformatf("op_%0d", i), obs_ops[i], x);
        end
        chk("rd_wr_overlap", both, 0);
        chk("fail_flag", fail, e_fail);
        chk("fail_addr", fail_addr, e_faddr);
        chk("fail_data", fail_data, e_fdata);
        chk("idle_outputs", {mif.test_mode, mif.mbist_rd, mif.mbist_wr, mif.mbist_addr, mif.mbist_din}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", {done, fail}, {1'b1, e_fail});
    endtask

    initial begin
        for (int i = 0; i < N; i++) ram[i] = 8'h00;
        f_en   = 0;
        f_addr = '0;
        f_mask = '0;
        f_sa1  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        build_ops();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {mif.test_mode, mif.mbist_rd, mif.mbist_wr, mif.mbist_addr,
             mif.mbist_din, done, fail, fail_addr, fail_data}, 0);
        rst = 1'b0;

        // Clean run, then a clean run with a start pulse mid-RUN.
        run_test(0, 0);
        chk("clean_done_cycle", done_cyc, 162);
        run_test(40, 0);

        // Bit 3 stuck-at-0 at address 5: caught by an e2 read.
        f_en = 1; f_addr = 4'd5; f_mask = 8'h08; f_sa1 = 0;
        run_test(0, 0);
        chk("sa0_fail_addr", fail_addr, 5);
        chk("sa0_fail_data", fail_data, 8'hF7);

        // Restart from DONE with the fault removed.
        f_en = 0;
        run_test(0, 0);

        // Bit 0 stuck-at-1 at address 0: caught by the first e1 read.
        f_en = 1; f_addr = 4'd0; f_mask = 8'h01; f_sa1 = 1;
        run_test(0, 0);
        chk("sa1_done_cycle", done_cyc, 19);
        chk("sa1_fail_data", fail_data, 8'h01);

        // Reset 50 cycles into a run, then a clean run.
        f_en = 0;
        run_test(0, 50);
        run_test(0, 0);

        for (int r = 0; r < 6; r++) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = 4'($urandom_range(0, N - 1));
            f_mask = 8'(1 << $urandom_range(0, 7));
            f_sa1  = 1'($urandom_range(0, 1));
            run_test(($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 150)) : 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
